// File: rtl/kpscan.sv
`timescale 1ns/1ps
// kpscan: 4x4 matrix keypad scanner with 2-FF row synchronizer and
// sample-based press/release debouncing. Reports a single key as row*4+col.
module kpscan #(
  parameter int SCAN_CYCLES    = 1000,
  parameter int DEBOUNCE_COUNT = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] kpr,
  output logic [3:0] kpc,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_press,
  output logic       key_release
);

  localparam int DW = $clog2(SCAN_CYCLES);
  localparam int CW = $clog2(DEBOUNCE_COUNT + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_COUNT - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  state_t          state, state_n;
  logic [3:0]      ks1, ksync;
  logic [DW-1:0]   dwell;
  logic            sample;
  logic            row_hit;
  logic [1:0]      row_idx, col_idx;
  logic [3:0]      kpc_n, kpc_rot;
  logic [3:0]      cand, cand_n;
  logic [CW-1:0]   cnt, cnt_n, rel, rel_n;
  logic [3:0]      key_n;
  logic            valid_n, press_n, release_n;
  logic [1:0]      cand_bit;
  logic            cand_low;

  // Two-stage synchronizer for the asynchronous row inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential logic uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would collapse the two stages into one.
    if (!reset_n) begin
      ks1   <= 4'b1111;
      ksync <= 4'b1111;
    end else begin
      ks1   <= kpr;
      ksync <= ks1;
    end
  end

  // Free-running column dwell counter; the last count is the sample point.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) dwell <= '0;
    else          dwell <= (dwell == DWELL_LAST) ? '0 : dwell + 1'b1;
  end

  assign sample   = (dwell == DWELL_LAST);
  assign kpc_rot  = {kpc[2:0], kpc[3]};
  assign cand_bit = 2'd3 - cand[3:2];
  assign cand_low = ~ksync[cand_bit];

  // Decode the synchronized rows (exactly one low bit) and the driven column.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    row_hit = 1'b1;
    row_idx = 2'd0;
    col_idx = 2'd0;
    case (ksync)
      4'b0111: row_idx = 2'd0;
      4'b1011: row_idx = 2'd1;
      4'b1101: row_idx = 2'd2;
      4'b1110: row_idx = 2'd3;
      default: row_hit = 1'b0;
    endcase
    case (kpc)
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
  end

  // Scan/debounce/held next-state and output logic, evaluated at each sample.
  always_comb begin
    state_n   = state;
    kpc_n     = kpc;
    cand_n    = cand;
    cnt_n     = cnt;
    rel_n     = rel;
    key_n     = key;
    valid_n   = key_valid;
    press_n   = 1'b0;
    release_n = 1'b0;
    if (sample) begin
      case (state)
        SCAN: begin
          if (row_hit) begin
            cand_n  = {row_idx, col_idx};
            cnt_n   = CW'(1);
            state_n = DEBOUNCE;
          end else begin
            kpc_n = kpc_rot;
          end
        end
        DEBOUNCE: begin
          if (row_hit && (row_idx == cand[3:2])) begin
            if (cnt == CNT_LAST) begin
              key_n   = cand;
              valid_n = 1'b1;
              press_n = 1'b1;
              cnt_n   = '0;
              state_n = HELD;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end else begin
            cnt_n   = '0;
            kpc_n   = kpc_rot;
            state_n = SCAN;
          end
        end
        HELD: begin
          if (cand_low) begin
            rel_n = '0;
          end else if (rel == CNT_LAST) begin
            rel_n     = '0;
            valid_n   = 1'b0;
            release_n = 1'b1;
            kpc_n     = kpc_rot;
            state_n   = SCAN;
          end else begin
            rel_n = rel + 1'b1;
          end
        end
        default: state_n = SCAN;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= SCAN;
      kpc         <= 4'b1110;
      cand        <= 4'd0;
      cnt         <= '0;
      rel         <= '0;
      key         <= 4'd0;
      key_valid   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      state       <= state_n;
      kpc         <= kpc_n;
      cand        <= cand_n;
      cnt         <= cnt_n;
      rel         <= rel_n;
      key         <= key_n;
      key_valid   <= valid_n;
      key_press   <= press_n;
      key_release <= release_n;
    end
  end

endmodule
